pc_sequencer: RTL and testbench

- Instruction-cycle controller for the 12-bit program counter. It sequences FETCH -> DECODE -> EXECUTE -> ADVANCE and drives the pc block's enable, jumpSelect and jumpAddr inputs.
- Arbitrates the next-PC source in priority order: interrupt vector, interrupt return, branch target, increment.
- Holds the interrupt return address and a fetch-timeout watchdog. Sits between the pc, instruction memory and the decode/execute datapath.

---
 rtl/pc_sequencer_if.sv | 44 ++++
 rtl/pc_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bus bundle between the instruction-cycle sequencer and its surroundings
// (pc block, instruction memory, decode/execute datapath).
//   master : the sequencer side (takes run/handshakes/irq, drives pc controls,
//            strobes and status)
//   slave  : the environment side (pc, memory, datapath, interrupt source)
// Signals:
//   run, pc_addr, fetch_ack, exec_done, branch_en, branch_addr, resume, irq
//     -> into the sequencer
//   pc_enable, pc_jump_select, pc_jump_addr, fetch_req, decode_en, exec_en,
//   in_isr, fault, state
//     -> out of the sequencer
interface pc_sequencer_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  run;
  logic [ADDR_WIDTH-1:0] pc_addr;
  logic                  fetch_ack;
  logic                  exec_done;
  logic                  branch_en;
  logic [ADDR_WIDTH-1:0] branch_addr;
  logic                  resume;
  logic                  irq;
  logic                  pc_enable;
  logic                  pc_jump_select;
  logic [ADDR_WIDTH-1:0] pc_jump_addr;
  logic                  fetch_req;
  logic                  decode_en;
  logic                  exec_en;
  logic                  in_isr;
  logic                  fault;
  logic [2:0]            state;

  modport master (
    input  run, pc_addr, fetch_ack, exec_done, branch_en, branch_addr, resume, irq,
    output pc_enable, pc_jump_select, pc_jump_addr, fetch_req, decode_en, exec_en,
           in_isr, fault, state
  );

  modport slave (
    output run, pc_addr, fetch_ack, exec_done, branch_en, branch_addr, resume, irq,
    input  pc_enable, pc_jump_select, pc_jump_addr, fetch_req, decode_en, exec_en,
           in_isr, fault, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction-cycle controller for the program counter.
// Sequences FETCH -> DECODE -> EXECUTE -> ADVANCE, arbitrates the next-PC
// source (interrupt vector > interrupt return > branch > increment), holds
// the interrupt return address and watches FETCH for a missing fetch_ack.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : pc_sequencer_if.master (handshakes in, pc controls/strobes out)
// All outputs are registered. The strobes are loaded together with the state
// register so they always equal a decode of the current state.
module pc_sequencer #(
  parameter int                  ADDR_WIDTH    = 12,
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR  = 12'h800,
  parameter int                  FETCH_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  pc_sequencer_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_ADVANCE = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam int WCW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(FETCH_TIMEOUT - 1);

  state_t                state_r;
  logic [3:0]            strobe_r;      // {fetch_req, decode_en, exec_en, pc_enable}
  logic                  jump_sel_r;
  logic [ADDR_WIDTH-1:0] jump_addr_r;
  logic                  in_isr_r;
  logic                  fault_r;
  logic                  irq_pending_r;
  logic [ADDR_WIDTH-1:0] saved_pc_r;
  logic [WCW-1:0]        wait_cnt_r;
  logic                  br_r;
  logic [ADDR_WIDTH-1:0] br_addr_r;
  logic                  res_r;
  logic [ADDR_WIDTH-1:0] next_pc_s;

  // Strobe pattern belonging to each state.
  function automatic logic [3:0] strobes_for(input state_t st);
    case (st)
      S_FETCH:   return 4'b1000;
      S_DECODE:  return 4'b0100;
      S_EXECUTE: return 4'b0010;
      S_ADVANCE: return 4'b0001;
      default:   return 4'b0000;
    endcase
  endfunction

  // Address the pc would reach without an interrupt: branch target or pc+1 (wraps).
  assign next_pc_s = br_r ? br_addr_r : (bus.pc_addr + ADDR_WIDTH'(1));

  // Sequencer FSM with registered strobes, jump controls and interrupt context.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      strobe_r      <= 4'b0000;
      jump_sel_r    <= 1'b0;
      jump_addr_r   <= '0;
      in_isr_r      <= 1'b0;
      fault_r       <= 1'b0;
      irq_pending_r <= 1'b0;
      saved_pc_r    <= '0;
      wait_cnt_r    <= '0;
      br_r          <= 1'b0;
      br_addr_r     <= '0;
      res_r         <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.run) begin
            state_r  <= S_FETCH;
            strobe_r <= strobes_for(S_FETCH);
          end else begin
            state_r  <= S_IDLE;
            strobe_r <= strobes_for(S_IDLE);
          end
        end

        S_FETCH: begin
          // An ack arriving on the last allowed cycle still wins over the timeout.
          if (bus.fetch_ack) begin
            state_r    <= S_DECODE;
            strobe_r   <= strobes_for(S_DECODE);
            wait_cnt_r <= '0;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r    <= S_FAULT;
            strobe_r   <= strobes_for(S_FAULT);
            fault_r    <= 1'b1;
            wait_cnt_r <= '0;
          end else begin
            wait_cnt_r <= wait_cnt_r + WCW'(1);
          end
        end

        S_DECODE: begin
          state_r  <= S_EXECUTE;
          strobe_r <= strobes_for(S_EXECUTE);
        end

        S_EXECUTE: begin
          if (bus.exec_done) begin
            state_r   <= S_ADVANCE;
            strobe_r  <= strobes_for(S_ADVANCE);
            br_r      <= bus.branch_en;
            br_addr_r <= bus.branch_addr;
            res_r     <= bus.resume;
            // Jump controls are decided here so they are registered in ADVANCE.
            // An irq arriving this cycle is already pending by ADVANCE, hence the OR.
            if (bus.resume && in_isr_r) begin
              jump_sel_r  <= 1'b1;
              jump_addr_r <= saved_pc_r;
            end else if ((irq_pending_r || bus.irq) && !in_isr_r) begin
              jump_sel_r  <= 1'b1;
              jump_addr_r <= IRQ_VECTOR;
            end else if (bus.branch_en) begin
              jump_sel_r  <= 1'b1;
              jump_addr_r <= bus.branch_addr;
            end else begin
              jump_sel_r  <= 1'b0;
              jump_addr_r <= '0;
            end
          end else begin
            state_r <= S_EXECUTE;
          end
        end

        S_ADVANCE: begin
          jump_sel_r  <= 1'b0;
          jump_addr_r <= '0;
          if (res_r && in_isr_r) begin
            in_isr_r <= 1'b0;
          end else if (irq_pending_r && !in_isr_r) begin
            saved_pc_r    <= next_pc_s;
            in_isr_r      <= 1'b1;
            irq_pending_r <= 1'b0;
          end else begin
            in_isr_r <= in_isr_r;
          end
          if (bus.run) begin
            state_r  <= S_FETCH;
            strobe_r <= strobes_for(S_FETCH);
          end else begin
            state_r  <= S_IDLE;
            strobe_r <= strobes_for(S_IDLE);
          end
        end

        S_FAULT: begin
          state_r  <= S_FAULT;
          strobe_r <= strobes_for(S_FAULT);
          fault_r  <= 1'b1;
        end

        default: begin
          state_r  <= S_IDLE;
          strobe_r <= 4'b0000;
        end
      endcase

      // A new request on the entry cycle itself is kept, so it overrides the clear above.
      if (bus.irq && (state_r != S_FAULT)) begin
        irq_pending_r <= 1'b1;
      end
    end
  end

  assign bus.fetch_req      = strobe_r[3];
  assign bus.decode_en      = strobe_r[2];
  assign bus.exec_en        = strobe_r[1];
  assign bus.pc_enable      = strobe_r[0];
  assign bus.pc_jump_select = jump_sel_r;
  assign bus.pc_jump_addr   = jump_addr_r;
  assign bus.in_isr         = in_isr_r;
  assign bus.fault          = fault_r;
  assign bus.state          = state_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a pc model closes the loop, a behavioural model
// predicts every output each cycle, and directed scenarios pin key values.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic check_en = 1'b0;

  logic        pc_load = 1'b0;
  logic [11:0] pc_load_val = 12'd0;

  pc_sequencer_if #(.ADDR_WIDTH(12)) bus_if ();

  pc_sequencer #(
    .ADDR_WIDTH(12),
    .IRQ_VECTOR(12'h800),
    .FETCH_TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // pc block: loads on jump, increments on enable, bench may preload it.
  always @(posedge clk) begin
    if (pc_load)
      bus_if.pc_addr <= pc_load_val;
    else if (bus_if.pc_enable)
      bus_if.pc_addr <= bus_if.pc_jump_select ? bus_if.pc_jump_addr : bus_if.pc_addr + 12'd1;
  end

  // ---------------- behavioural model ----------------
  int          m_phase;     // spec state code
  int          m_wait;      // FETCH cycles already spent without ack
  logic        m_pending, m_in_isr, m_br, m_res;
  logic [11:0] m_saved, m_br_addr;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0; m_wait <= 0; m_pending <= 1'b0; m_in_isr <= 1'b0;
      m_br <= 1'b0; m_res <= 1'b0; m_saved <= 12'd0; m_br_addr <= 12'd0;
    end else begin
      if (m_phase == 0) m_phase <= bus_if.run ? 1 : 0;
      if (m_phase == 1) begin
        if (bus_if.fetch_ack) begin m_phase <= 2; m_wait <= 0; end
        else if (m_wait + 1 >= 16) begin m_phase <= 5; m_wait <= 0; end
        else m_wait <= m_wait + 1;
      end
      if (m_phase == 2) m_phase <= 3;
      if (m_phase == 3 && bus_if.exec_done) begin
        m_phase <= 4; m_br <= bus_if.branch_en; m_br_addr <= bus_if.branch_addr;
        m_res <= bus_if.resume;
      end
      if (m_phase == 4) begin
        m_phase <= bus_if.run ? 1 : 0;
        if (m_res && m_in_isr) m_in_isr <= 1'b0;
        else if (m_pending) begin
          m_in_isr <= 1'b1;
          m_pending <= bus_if.irq;
          m_saved <= m_br ? m_br_addr : bus_if.pc_addr + 12'd1;
        end
      end
      if (bus_if.irq && m_phase != 5) m_pending <= 1'b1;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [21:0] act, exp;
    logic        ejs;
    logic [11:0] eja;
    if (check_en) begin
      ejs = 1'b0; eja = 12'd0;
      if (m_phase == 4) begin
        if (m_res && m_in_isr) begin ejs = 1'b1; eja = m_saved; end
        else if (m_pending && !m_in_isr) begin ejs = 1'b1; eja = 12'h800; end
        else if (m_br) begin ejs = 1'b1; eja = m_br_addr; end
      end
      exp = {3'(m_phase), m_phase == 1, m_phase == 2, m_phase == 3, m_phase == 4,
             ejs, eja, m_in_isr, m_phase == 5};
      act = {bus_if.state, bus_if.fetch_req, bus_if.decode_en, bus_if.exec_en,
             bus_if.pc_enable, bus_if.pc_jump_select, bus_if.pc_jump_addr,
             bus_if.in_isr, bus_if.fault};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL cycle t=%0t outputs got=%h want=%h", $time, act, exp);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (bus_if.state !== s && n < budget) begin tick(1); n++; end
    check(name, 32'(bus_if.state), 32'(s));
  endtask

  task automatic set_pc(input logic [11:0] v);
    pc_load = 1'b1; pc_load_val = v;
    tick(1);
    pc_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // One instruction from IDLE or FETCH; leaves the bench just after ADVANCE.
  task automatic one_instr(input logic br, input logic [11:0] ba, input logic rs,
                           input logic irq_dec, input logic keep_run,
                           output logic o_js, output logic [11:0] o_ja);
    bus_if.run = 1'b1; bus_if.fetch_ack = 1'b1; bus_if.exec_done = 1'b0;
    wait_state(3'd2, 40, "reach_decode");
    bus_if.irq = irq_dec;
    tick(1);
    bus_if.irq = 1'b0;
    bus_if.branch_en = br; bus_if.branch_addr = ba; bus_if.resume = rs;
    bus_if.exec_done = 1'b1; bus_if.run = keep_run;
    tick(1);
    o_js = bus_if.pc_jump_select; o_ja = bus_if.pc_jump_addr;
    bus_if.exec_done = 1'b0; bus_if.branch_en = 1'b0; bus_if.resume = 1'b0;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic        js;
    logic [11:0] ja;
    int          n;
    reset = 1'b1;
    bus_if.run = 1'b0; bus_if.fetch_ack = 1'b0; bus_if.exec_done = 1'b0;
    bus_if.branch_en = 1'b0; bus_if.branch_addr = 12'd0; bus_if.resume = 1'b0;
    bus_if.irq = 1'b0;
    pc_load = 1'b1; pc_load_val = 12'd0;
    tick(1);
    check_en = 1'b1;
    tick(1);
    pc_load = 1'b0;
    reset = 1'b0;
    check("reset_state", 32'(bus_if.state), 32'd0);
    check("reset_outs", {bus_if.fetch_req, bus_if.decode_en, bus_if.exec_en,
          bus_if.pc_enable, bus_if.pc_jump_select, bus_if.in_isr, bus_if.fault},
          32'd0);
    check("reset_jaddr", 32'(bus_if.pc_jump_addr), 32'd0);

    // Free-running: ack and exec_done tied high.
    bus_if.run = 1'b1; bus_if.fetch_ack = 1'b1; bus_if.exec_done = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_state(3'd4, 10, "free_adv");
      tick(1);
      check("free_pc", 32'(bus_if.pc_addr), 32'(k));
    end
    n = 0;
    repeat (8) begin if (bus_if.pc_enable) n++; tick(1); end
    check("pc_enable_duty", 32'(n), 32'd2);
    bus_if.run = 1'b0;
    wait_state(3'd0, 10, "free_stop");
    bus_if.exec_done = 1'b0;

    // Branch from pc=5.
    set_pc(12'd5);
    one_instr(1'b1, 12'h123, 1'b0, 1'b0, 1'b0, js, ja);
    check("br_jsel", 32'(js), 32'd1);
    check("br_jaddr", 32'(ja), 32'h123);
    check("br_pc", 32'(bus_if.pc_addr), 32'h123);

    // Interrupt entry from pc=0x010 and return.
    set_pc(12'h010);
    one_instr(1'b0, 12'd0, 1'b0, 1'b1, 1'b1, js, ja);
    check("irq_pc", 32'(bus_if.pc_addr), 32'h800);
    check("irq_in_isr", 32'(bus_if.in_isr), 32'd1);
    one_instr(1'b0, 12'd0, 1'b1, 1'b0, 1'b1, js, ja);
    check("ret_pc", 32'(bus_if.pc_addr), 32'h011);
    check("ret_in_isr", 32'(bus_if.in_isr), 32'd0);

    // irq inside ISR, resume in same instruction: return first, re-vector next.
    one_instr(1'b0, 12'd0, 1'b0, 1'b1, 1'b1, js, ja);
    check("irq2_pc", 32'(bus_if.pc_addr), 32'h800);
    one_instr(1'b0, 12'd0, 1'b1, 1'b1, 1'b1, js, ja);
    check("ret2_pc", 32'(bus_if.pc_addr), 32'h012);
    check("ret2_in_isr", 32'(bus_if.in_isr), 32'd0);
    one_instr(1'b0, 12'd0, 1'b0, 1'b0, 1'b0, js, ja);
    check("revector_pc", 32'(bus_if.pc_addr), 32'h800);
    check("revector_in_isr", 32'(bus_if.in_isr), 32'd1);

    // Fetch timeout.
    do_reset();
    check("rst2_in_isr", 32'(bus_if.in_isr), 32'd0);
    bus_if.run = 1'b1; bus_if.fetch_ack = 1'b0;
    wait_state(3'd1, 10, "to_fetch");
    bus_if.run = 1'b0;
    n = 0;
    while (bus_if.state == 3'd1 && n < 40) begin n++; tick(1); end
    check("timeout_cycles", 32'(n), 32'd16);
    check("timeout_state", 32'(bus_if.state), 32'd5);
    check("timeout_fault", 32'(bus_if.fault), 32'd1);
    tick(3);
    check("fault_sticky", 32'(bus_if.fault), 32'd1);
    do_reset();
    check("fault_clear_state", 32'(bus_if.state), 32'd0);
    check("fault_clear", 32'(bus_if.fault), 32'd0);

    // Ack on the 16th FETCH cycle wins.
    bus_if.run = 1'b1;
    wait_state(3'd1, 10, "to_fetch2");
    bus_if.run = 1'b0;
    tick(15);
    bus_if.fetch_ack = 1'b1;
    tick(1);
    check("late_ack_state", 32'(bus_if.state), 32'd2);
    check("late_ack_fault", 32'(bus_if.fault), 32'd0);
    bus_if.exec_done = 1'b1;
    wait_state(3'd0, 10, "late_ack_idle");
    bus_if.exec_done = 1'b0;

    // Wrap at 0xFFF, run dropped during EXECUTE.
    set_pc(12'hFFF);
    one_instr(1'b0, 12'd0, 1'b0, 1'b0, 1'b0, js, ja);
    check("wrap_pc", 32'(bus_if.pc_addr), 32'd0);
    check("stop_state", 32'(bus_if.state), 32'd0);
    n = 0;
    repeat (5) begin if (bus_if.fetch_req) n++; tick(1); end
    check("stop_no_fetch", 32'(n), 32'd0);

    // Reset during EXECUTE inside an ISR with an irq pending.
    set_pc(12'h020);
    one_instr(1'b0, 12'd0, 1'b0, 1'b1, 1'b1, js, ja);
    check("isr3_pc", 32'(bus_if.pc_addr), 32'h800);
    wait_state(3'd3, 10, "isr3_exec");
    bus_if.irq = 1'b1;
    tick(1);
    bus_if.irq = 1'b0;
    bus_if.run = 1'b0;
    reset = 1'b1;
    tick(1);
    check("rst_exec_state", 32'(bus_if.state), 32'd0);
    check("rst_exec_in_isr", 32'(bus_if.in_isr), 32'd0);
    reset = 1'b0;
    one_instr(1'b0, 12'd0, 1'b0, 1'b0, 1'b0, js, ja);
    check("pending_dropped_pc", 32'(bus_if.pc_addr), 32'h801);
    check("pending_dropped_isr", 32'(bus_if.in_isr), 32'd0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
